// File: rtl/edge_detect_stream.sv
// Streaming 3x3 Sobel / grayscale engine: RGB in raster order, two line buffers,
// fixed three-edge latency from accepting edge to registered output.
module edge_detect_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 12,
    parameter int X_W   = 10,
    parameter int Y_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             valid,
    input  logic [X_W-1:0]   x_cntr,
    input  logic [Y_W-1:0]   y_cntr,
    input  logic [PIX_W-1:0] pixel_r,
    input  logic [PIX_W-1:0] pixel_g,
    input  logic [PIX_W-1:0] pixel_b,
    output logic             out_valid,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic [PIX_W-1:0] pixel_out,
    output logic             frame_done
);

    localparam int GW = PIX_W + 2;
    localparam int SW = PIX_W + 4;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    function automatic logic signed [SW-1:0] tri_sum(input logic [PIX_W-1:0] a,
                                                     input logic [PIX_W-1:0] b,
                                                     input logic [PIX_W-1:0] c);
        return $signed({4'b0, a} + {3'b0, b, 1'b0} + {4'b0, c});
    endfunction

    function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
        return v[SW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [SW-1:0] v);
        return (v > {4'b0, PIX_MAX}) ? PIX_MAX : v[PIX_W-1:0];
    endfunction

    logic             accept;
    logic             frame_start;
    logic [GW-1:0]    gray_sum;
    logic [PIX_W-1:0] gray;
    logic [1:0]       mode_q;
    logic             armed_q;

    assign accept      = valid && (32'(x_cntr) < IMG_W) && (32'(y_cntr) < IMG_H);
    assign frame_start = (x_cntr == '0) && (y_cntr == '0);
    assign gray_sum    = GW'(pixel_r) + {1'b0, pixel_g, 1'b0} + GW'(pixel_b);
    assign gray        = gray_sum[GW-1:2];

    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[x_cntr] <= lb1[x_cntr];
            lb1[x_cntr] <= gray;
        end
    end

    // ---- stage p0: window shift, centre coordinate, per-beat mode
    logic [PIX_W-1:0] win_p0 [3][3];
    logic             vld_p0;
    logic [X_W-1:0]   cx_p0;
    logic [Y_W-1:0]   cy_p0;
    logic [1:0]       mode_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            mode_q  <= 2'd0;
            armed_q <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p0[r][c] <= '0;
        end else begin
            vld_p0 <= accept && armed_q && (x_cntr != '0) && (y_cntr != '0);
            if (accept) begin
                if (frame_start) begin
                    mode_q  <= mode;
                    armed_q <= 1'b1;
                end
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= lb0[x_cntr];
                win_p0[1][2] <= lb1[x_cntr];
                win_p0[2][2] <= gray;
            end
        end
    end

    // Mode travels with each beat so back-to-back frames never mix settings.
    always_ff @(posedge clk) begin
        if (accept) begin
            cx_p0   <= x_cntr - X_W'(1);
            cy_p0   <= y_cntr - Y_W'(1);
            mode_p0 <= frame_start ? mode : mode_q;
        end
    end

    // ---- stage p1: gradients and magnitudes
    logic signed [SW-1:0] gx;
    logic signed [SW-1:0] gy;
    assign gx = tri_sum(win_p0[0][2], win_p0[1][2], win_p0[2][2])
              - tri_sum(win_p0[0][0], win_p0[1][0], win_p0[2][0]);
    assign gy = tri_sum(win_p0[2][0], win_p0[2][1], win_p0[2][2])
              - tri_sum(win_p0[0][0], win_p0[0][1], win_p0[0][2]);

    logic             vld_p1;
    logic [SW-1:0]    agx_p1;
    logic [SW-1:0]    agy_p1;
    logic [PIX_W-1:0] ctr_p1;
    logic [1:0]       mode_p1;
    logic [X_W-1:0]   cx_p1;
    logic [Y_W-1:0]   cy_p1;
    logic             border_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        agx_p1    <= abs_val(gx);
        agy_p1    <= abs_val(gy);
        ctr_p1    <= win_p0[1][1];
        mode_p1   <= mode_p0;
        cx_p1     <= cx_p0;
        cy_p1     <= cy_p0;
        border_p1 <= (cx_p0 == '0) || (cy_p0 == '0);
    end

    // ---- stage p2: mode select, saturation, border mask, registered outputs
    logic [PIX_W-1:0] result;
    always_comb begin
        result = '0;
        case (mode_p1)
            2'd0:    result = sat_pix(agx_p1);
            2'd1:    result = sat_pix(agy_p1);
            2'd2:    result = sat_pix(agx_p1 + agy_p1);
            default: result = ctr_p1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            pixel_out  <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_x      <= cx_p1;
                out_y      <= cy_p1;
                pixel_out  <= border_p1 ? '0 : result;
                frame_done <= (32'(cx_p1) == IMG_W - 2) && (32'(cy_p1) == IMG_H - 2);
            end else begin
                pixel_out  <= '0;
                frame_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_detect_stream.sv
// Randomised stream bench for edge_detect_stream on a small image, checked
// against an image-array Sobel model with cycle-exact expected output times.
module tb_edge_detect_stream;

    localparam int W   = 12;
    localparam int H   = 10;
    localparam int P   = 12;
    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int MAXV = 4095;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          valid;
    logic [XW-1:0] x_cntr;
    logic [YW-1:0] y_cntr;
    logic [P-1:0]  pixel_r, pixel_g, pixel_b;
    logic          out_valid;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [P-1:0]  pixel_out;
    logic          frame_done;

    edge_detect_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .valid(valid),
        .x_cntr(x_cntr), .y_cntr(y_cntr),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .pixel_out(pixel_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        int x;
        int y;
        int pix;
        int done;
    } exp_t;

    exp_t q[$];
    int   img [H][W];
    int   fmode;
    bit   armed;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel evaluated directly on the stored grayscale frame.
    function automatic int ref_pix(input int cx, input int cy, input int m);
        int gx, gy, v;
        if (cx == 0 || cy == 0) return 0;
        if (m == 3) return img[cy][cx];
        gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
        gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
        case (m)
            0:       v = iabs(gx);
            1:       v = iabs(gy);
            default: v = iabs(gx) + iabs(gy);
        endcase
        return (v > MAXV) ? MAXV : v;
    endfunction

    task automatic check_out();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", 32'(out_valid), 1);
            chk("out_x", 32'(out_x), e.x);
            chk("out_y", 32'(out_y), e.y);
            chk("pixel_out", 32'(pixel_out), e.pix);
            chk("frame_done", 32'(frame_done), e.done);
        end else begin
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_done", 32'(frame_done), 0);
        end
    endtask

    task automatic step(input bit v, input int x, input int y,
                        input int r, input int g, input int b, input int m);
        exp_t e;
        valid   = v;
        x_cntr  = XW'(x);
        y_cntr  = YW'(y);
        pixel_r = P'(r);
        pixel_g = P'(g);
        pixel_b = P'(b);
        mode    = 2'(m);
        @(posedge clk);
        #1;
        check_out();
        if (v && x < W && y < H) begin
            if (x == 0 && y == 0) begin
                fmode = m;
                armed = 1'b1;
            end
            img[y][x] = (r + 2*g + b) / 4;
            if (armed && x > 0 && y > 0) begin
                e.due  = cyc + 2;
                e.x    = x - 1;
                e.y    = y - 1;
                e.pix  = ref_pix(x - 1, y - 1, fmode);
                e.done = (x - 1 == W - 2 && y - 1 == H - 2) ? 1 : 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset_pulse();
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pix", 32'(pixel_out), 0);
        q.delete();
        armed = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(out_valid), 0);
        chk("rst_hold_pix", 32'(pixel_out), 0);
        rst = 1'b0;
    endtask

    // kind: 0 uniform 100, 1 vertical step 1000, 2 vertical step 4095,
    //       3 horizontal step 1000, 4 random full range
    task automatic run_frame(input int kind, input int m, input int gap_pct,
                             input int oor_pct, input int rst_at);
        int r, g, b, v;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                while ($urandom_range(99) < gap_pct)
                    step(1'b0, $urandom_range(15), $urandom_range(15),
                         $urandom_range(MAXV), $urandom_range(MAXV), $urandom_range(MAXV),
                         $urandom_range(3));
                if ($urandom_range(99) < oor_pct) begin
                    if ($urandom_range(1) == 0)
                        step(1'b1, $urandom_range(15, W), $urandom_range(H - 1),
                             $urandom_range(MAXV), $urandom_range(MAXV), $urandom_range(MAXV),
                             $urandom_range(3));
                    else
                        step(1'b1, $urandom_range(W - 1), $urandom_range(15, H),
                             $urandom_range(MAXV), $urandom_range(MAXV), $urandom_range(MAXV),
                             $urandom_range(3));
                end
                case (kind)
                    0:       v = 100;
                    1:       v = (x >= W/2) ? 1000 : 0;
                    2:       v = (x >= W/2) ? MAXV : 0;
                    3:       v = (y >= H/2) ? 1000 : 0;
                    default: v = -1;
                endcase
                if (v < 0) begin
                    r = $urandom_range(MAXV);
                    g = $urandom_range(MAXV);
                    b = $urandom_range(MAXV);
                end else begin
                    r = v; g = v; b = v;
                end
                step(1'b1, x, y, r, g, b, (x == 0 && y == 0) ? m : $urandom_range(3));
                if (y * W + x == rst_at) do_reset_pulse();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0; mode = 2'd0; x_cntr = '0; y_cntr = '0;
        pixel_r = '0; pixel_g = '0; pixel_b = '0;
        armed = 1'b0; fmode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_pix", 32'(pixel_out), 0);
        chk("reset_done", 32'(frame_done), 0);
        chk("reset_x", 32'(out_x), 0);
        chk("reset_y", 32'(out_y), 0);
        rst = 1'b0;

        run_frame(0, 3, 0, 0, -1);
        run_frame(0, 2, 0, 0, -1);
        run_frame(1, 0, 0, 0, -1);
        run_frame(1, 1, 0, 0, -1);
        run_frame(2, 0, 30, 10, -1);
        run_frame(3, 1, 30, 10, -1);
        run_frame(4, 2, 30, 10, -1);
        run_frame(4, 3, 0, 0, -1);
        run_frame(4, 0, 0, 0, -1);
        run_frame(4, 2, 20, 5, 4 * W + 5);
        run_frame(4, 1, 0, 0, -1);
        run_frame(2, 2, 30, 10, -1);

        repeat (4) step(1'b0, 0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/edge_detect_stream.md
Name: edge_detect_stream

Overview:
Parametrised, fully pipelined successor to the edge detector for the camera-to-display path. It accepts one RGB pixel per valid beat in raster order and converts it to grayscale. Two on-chip line buffers build a 3x3 window, and the block emits a Sobel-H, Sobel-V, combined-magnitude or grayscale-passthrough result with a coordinate-tagged output valid. Mode is frame-synchronous, and border, saturation and out-of-range behaviour are explicitly defined.

Parameters:
IMG_W, 640, active pixels per line (line buffer depth)
IMG_H, 480, active lines per frame
PIX_W, 12, bits per colour channel and per output pixel
X_W, 10, x coordinate width (2**X_W >= IMG_W)
Y_W, 10, y coordinate width (2**Y_W >= IMG_H)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
mode  in  2  0=|Gx| Sobel horizontal, 1=|Gy| Sobel vertical, 2=|Gx|+|Gy|, 3=grayscale passthrough
valid  in  1  input beat qualifier
x_cntr  in  X_W  input pixel column
y_cntr  in  Y_W  input pixel row
pixel_r  in  PIX_W  red
pixel_g  in  PIX_W  green
pixel_b  in  PIX_W  blue
out_valid  out  1  output beat qualifier
out_x  out  X_W  output pixel column
out_y  out  Y_W  output pixel row
pixel_out  out  PIX_W  result
frame_done  out  1  one-cycle pulse with the last output beat of a frame

Behaviour:
- Clocking and reset: one clock domain (clk). rst is asynchronous, active-high. Reset clears out_valid, out_x, out_y, pixel_out, frame_done, the window registers, the pipeline valids and the latched mode (mode reset value is 0). Line buffer RAM is not cleared; the border rule masks stale contents.
- Beat acceptance:
  - A beat is accepted when valid=1, x_cntr<IMG_W and y_cntr<IMG_H.
  - Out-of-range beats are dropped: no state update and no output.
  - Gaps (valid=0) freeze all window and line buffer state.
- Grayscale: gray = (r + 2g + b) >> 2, computed at PIX_W+2 internal width; the result fits PIX_W.
- Mode latch: mode is sampled only on an accepted beat with x_cntr=0 and y_cntr=0. A mode change mid-frame takes effect at the next frame.
- Line buffers:
  - On each accepted beat at column x: lb0[x] <= lb1[x] (old value) and lb1[x] <= gray.
  - lb1 holds row y-1 and lb0 holds row y-2.
  - The window shifts in column {lb0[x], lb1[x], gray} as its right column.
- Output geometry:
  - An accepted beat at (x,y) with x>=1 and y>=1 produces exactly one output beat for centre (x-1,y-1), with out_x=x-1 and out_y=y-1.
  - No output is produced for beats with x=0 or y=0. The output frame is coordinates 0..IMG_W-2 by 0..IMG_H-2.
- Latency: out_valid and its data are asserted on the 2nd rising edge after the accepting edge, i.e. visible in cycle N+2 for an input accepted at edge N.
  - The pipeline advances every clock regardless of valid, so latency is fixed.
  - out_valid is 0 in every cycle that has no qualifying beat.
- Arithmetic:
  - Gx = right column minus left column with weights 1,2,1. Gy = bottom row minus top row with weights 1,2,1.
  - Gx and Gy are signed PIX_W+4 bits. The absolute value is taken before summing.
- Result per latched mode:
  - mode 0: sat(|Gx|).
  - mode 1: sat(|Gy|).
  - mode 2: sat(|Gx|+|Gy|).
  - mode 3: centre gray.
  - sat() clamps to 2**PIX_W-1.
- Border: when out_x=0 or out_y=0, pixel_out=0 in all modes (out_valid is still asserted).
- frame_done: asserted together with the output beat for (IMG_W-2, IMG_H-2).
- Reset mid-frame: the in-flight pipeline is discarded, with no output beats after rst. Output restarts cleanly from the next (0,0) beat.
- Back-to-back frames: supported with zero idle cycles between the last beat of one frame and (0,0) of the next.

Test Plan:
- Uniform frame, r=g=b=100, mode 0/1/2 -> every out_valid beat has pixel_out=0; mode 3 -> interior outputs 100, border (out_x=0 or out_y=0) outputs 0; exactly 639*479 beats; one frame_done at (638,478).
- Vertical step, x<320 rgb=0 and x>=320 rgb=1000, mode 0 -> pixel_out=4000 at out_x=319 and 320 (all rows >=1), 0 elsewhere; mode 1 -> all 0; mode 2 -> 4000 at the same columns.
- Vertical step to rgb=4095, mode 0 -> columns 319/320 saturate to 4095 (raw 16380); horizontal step at y=240 rgb=1000, mode 1 -> 4000 at out_y=239 and 240.
- Mode driven 0 at (0,0) and then 1 from pixel (0,100) -> whole frame computed as mode 0; next frame computed as mode 1.
- Random valid gaps (~30% idle) and beats with x_cntr=700 or y_cntr=500 interleaved -> output stream identical to the gap-free run; out-of-range beats produce nothing; every output appears exactly 2 cycles after its accepting beat.
- rst pulsed at pixel (200,150) -> out_valid=0 and pixel_out=0 immediately and thereafter until the next frame; after restarting at (0,0) the full frame matches the golden output.
